// File: rtl/prg_cache_bridge.sv
// Cartridge PRG bus to SDRAM bridge with a small direct-mapped 16-bit read cache.
// Reads are cached, writes go through to SDRAM; one extra strobe event can be queued.
module prg_cache_bridge #(
    parameter int ADDR_BITS   = 23,
    parameter int LINES       = 8,
    parameter int SYNC_STAGES = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [7:0]           data_in,
    output logic [7:0]           data_out,
    input  logic                 oe,
    input  logic                 we,
    output logic                 refresh,
    output logic                 overflow,
    output logic                 ram_req,
    output logic                 ram_we,
    output logic [ADDR_BITS-2:0] ram_addr,
    output logic [15:0]          ram_wdata,
    output logic [1:0]           ram_wm,
    input  logic [15:0]          ram_rdata,
    input  logic                 ram_ack
);
    localparam int WORD_W = ADDR_BITS - 1;
    localparam int IDX_W  = $clog2(LINES);
    localparam int TAG_W  = WORD_W - IDX_W;

    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;
    state_t state, state_next;

    logic [SYNC_STAGES-1:0] oe_sync, we_sync;
    logic                   rd_evt, wr_evt;

    logic [LINES-1:0] line_valid;
    logic [TAG_W-1:0] line_tag  [LINES];
    logic [15:0]      line_data [LINES];

    logic                 pend_valid, pend_we;
    logic [ADDR_BITS-1:0] pend_addr;
    logic [7:0]           pend_data;

    logic                 go, go_we, go_hit;
    logic [ADDR_BITS-1:0] go_addr;
    logic [7:0]           go_data;
    logic [WORD_W-1:0]    go_word;
    logic [IDX_W-1:0]     go_idx;
    logic [TAG_W-1:0]     go_tag;
    logic                 q_in, q_we, drop;
    logic                 do_hit, do_miss, do_write, do_fill;

    logic [ADDR_BITS-1:0] cur_addr;
    logic [WORD_W-1:0]    cur_word;
    logic [IDX_W-1:0]     cur_idx;
    logic [TAG_W-1:0]     cur_tag;

    always_ff @(posedge clk) begin
        if (reset) begin
            oe_sync <= '0;
            we_sync <= '0;
        end else begin
            oe_sync <= {oe_sync[SYNC_STAGES-2:0], oe};
            we_sync <= {we_sync[SYNC_STAGES-2:0], we};
        end
    end

    assign rd_evt = oe_sync[SYNC_STAGES-2] & ~oe_sync[SYNC_STAGES-1];
    assign wr_evt = ~we_sync[SYNC_STAGES-2] & we_sync[SYNC_STAGES-1];

    // A queued event always beats a fresh one; a write colliding with a read waits behind it.
    always_comb begin
        go      = 1'b0;
        go_we   = 1'b0;
        go_addr = addr;
        go_data = data_in;
        q_in    = 1'b0;
        q_we    = 1'b0;
        drop    = 1'b0;
        if (state == IDLE) begin
            if (pend_valid) begin
                go      = 1'b1;
                go_we   = pend_we;
                go_addr = pend_addr;
                go_data = pend_data;
                if (rd_evt) begin
                    q_in = 1'b1;
                    drop = wr_evt;
                end else if (wr_evt) begin
                    q_in = 1'b1;
                    q_we = 1'b1;
                end
            end else if (rd_evt) begin
                go   = 1'b1;
                q_in = wr_evt;
                q_we = 1'b1;
            end else if (wr_evt) begin
                go    = 1'b1;
                go_we = 1'b1;
            end
        end else if (rd_evt || wr_evt) begin
            if (pend_valid) begin
                drop = 1'b1;
            end else begin
                q_in = 1'b1;
                q_we = ~rd_evt;
                drop = rd_evt & wr_evt;
            end
        end
    end

    assign go_word  = go_addr[ADDR_BITS-1:1];
    assign go_idx   = go_word[IDX_W-1:0];
    assign go_tag   = go_word[WORD_W-1:IDX_W];
    assign go_hit   = line_valid[go_idx] && (line_tag[go_idx] == go_tag);
    assign cur_word = cur_addr[ADDR_BITS-1:1];
    assign cur_idx  = cur_word[IDX_W-1:0];
    assign cur_tag  = cur_word[WORD_W-1:IDX_W];

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        do_hit     = 1'b0;
        do_miss    = 1'b0;
        do_write   = 1'b0;
        do_fill    = 1'b0;
        case (state)
            IDLE: begin
                if (go) begin
                    if (go_we) begin
                        do_write   = 1'b1;
                        state_next = WR_WAIT;
                    end else if (go_hit) begin
                        do_hit = 1'b1;
                    end else begin
                        do_miss    = 1'b1;
                        state_next = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (ram_ack) begin
                    do_fill    = 1'b1;
                    state_next = IDLE;
                end
            end
            WR_WAIT: begin
                if (ram_ack) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            line_valid <= '0;
            ram_req    <= 1'b0;
            refresh    <= 1'b0;
            overflow   <= 1'b0;
            pend_valid <= 1'b0;
            pend_we    <= 1'b0;
            pend_addr  <= '0;
            pend_data  <= '0;
            data_out   <= 8'h00;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            ram_wm     <= '0;
            cur_addr   <= '0;
        end else begin
            ram_req <= do_miss | do_write;
            refresh <= do_hit;
            if (drop) overflow <= 1'b1;
            if (q_in) begin
                pend_valid <= 1'b1;
                pend_we    <= q_we;
                pend_addr  <= addr;
                pend_data  <= data_in;
            end else if (state == IDLE && pend_valid) begin
                pend_valid <= 1'b0;
            end
            if (do_hit) data_out <= go_addr[0] ? line_data[go_idx][15:8] : line_data[go_idx][7:0];
            if (do_miss) begin
                ram_we   <= 1'b0;
                ram_addr <= go_word;
                cur_addr <= go_addr;
            end
            if (do_write) begin
                ram_we    <= 1'b1;
                ram_addr  <= go_word;
                ram_wdata <= {go_data, go_data};
                ram_wm    <= go_addr[0] ? 2'b01 : 2'b10;
            end
            if (do_fill) begin
                line_valid[cur_idx] <= 1'b1;
                data_out <= cur_addr[0] ? ram_rdata[15:8] : ram_rdata[7:0];
            end
        end
    end

    // Tag/data arrays need no reset; the valid bits alone gate their use.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (do_fill) begin
                line_tag[cur_idx]  <= cur_tag;
                line_data[cur_idx] <= ram_rdata;
            end
            if (do_write && go_hit) begin
                if (go_addr[0]) line_data[go_idx][15:8] <= go_data;
                else            line_data[go_idx][7:0]  <= go_data;
            end
        end
    end
endmodule

// File: doc/prg_cache_bridge.md
PRG_CACHE_BRIDGE -- requirements
Module: prg_cache_bridge

Interface
REQ-001 Parameter ADDR_BITS, default 23, SHALL set the byte-address width; the SDRAM word address is ADDR_BITS-1 bits.
REQ-002 Parameter LINES, default 8, power of two >= 2, SHALL set the number of direct-mapped 16-bit cache lines.
REQ-003 Parameter SYNC_STAGES, default 3, minimum 2, SHALL set the synchroniser depth applied to oe and we.
REQ-004 clk  in  1  sole clock; all logic SHALL be on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 addr  in  ADDR_BITS  cartridge byte address; addr[0] selects the byte (1 = high byte).
REQ-007 data_in  in  8  cartridge write data.
REQ-008 data_out  out  8  registered read data.
REQ-009 oe, we  in  1 each  asynchronous cartridge read/write strobes.
REQ-010 refresh  out  1  one-cycle pulse granting the SDRAM controller an idle slot.
REQ-011 overflow  out  1  sticky flag: a strobe event was dropped.
REQ-012 ram_req  out  1  one-cycle request pulse.
REQ-013 ram_we  out  1  request type: 1 = write, 0 = read.
REQ-014 ram_addr  out  ADDR_BITS-1  word address.
REQ-015 ram_wdata  out  16; ram_wm  out  2  write data {data_in,data_in} and byte mask (2'b01 = write high byte, 2'b10 = write low byte; a set bit masks its byte).
REQ-016 ram_rdata  in  16; ram_ack  in  1  ram_ack pulses for one cycle when a read's ram_rdata is valid or a write has completed.

Function
REQ-017 oe and we SHALL each pass through SYNC_STAGES flip-flops; a read event SHALL be an oe 0->1 transition and a write event a we 1->0 transition, both detected on the last two synchroniser stages.
REQ-018 Each line SHALL hold valid, tag (word address bits above log2(LINES)) and 16 data bits, indexed by word-address bits [log2(LINES)-1:0].
REQ-019 FSM states SHALL be IDLE, RD_WAIT and WR_WAIT.
REQ-020 Read event in IDLE, hit: data_out SHALL update to the selected byte on the next cycle, refresh SHALL pulse that same cycle, no ram_req SHALL issue, and the state SHALL stay IDLE.
REQ-021 Read event in IDLE, miss: on the next cycle ram_req=1, ram_we=0 and ram_addr=addr[ADDR_BITS-1:1]; the state SHALL become RD_WAIT.
REQ-022 In RD_WAIT, on ram_ack the line SHALL be filled (valid=1, tag, ram_rdata), data_out SHALL update to the selected byte on the next cycle, and the state SHALL return to IDLE.
REQ-023 Write event in IDLE: the next cycle SHALL issue ram_req with ram_we=1 and the REQ-015 data/mask, and the state SHALL become WR_WAIT (write-through).
REQ-024 On a write hit, the addressed byte of the line SHALL be updated in the same cycle as ram_req; a write miss SHALL not allocate a line.
REQ-025 In WR_WAIT, ram_ack SHALL return the state to IDLE.
REQ-026 An event arriving outside IDLE SHALL be captured, with its address and data, into a one-entry pending slot; it SHALL be executed on the first IDLE cycle, with priority over a new event in that cycle.
REQ-027 An event arriving while the pending slot is full SHALL be dropped and SHALL set overflow, which is cleared only by reset.
REQ-028 If a read event and a write event are detected in the same cycle, the read SHALL execute first and the write SHALL go to the pending slot.
REQ-029 Line indices SHALL wrap modulo LINES; addresses differing only above the index bits SHALL evict each other.
REQ-030 ram_ack in IDLE SHALL be ignored.
REQ-031 Only one SDRAM request SHALL be outstanding at any time.

Reset
REQ-032 While reset is high: all valid bits, ram_req, refresh, overflow, the pending slot and the synchronisers SHALL clear; data_out SHALL be 8'h00 and state IDLE.
REQ-033 Reset during RD_WAIT or WR_WAIT SHALL abandon the transaction without filling a line; the first event after reset SHALL be served normally.

Verification
REQ-034 Cold read of addr 0x000101 with ram_rdata=16'hBEEF on ack -> one ram_req (ram_we=0, ram_addr=0x000080), data_out=8'hBE one cycle after ack.
REQ-035 Repeat read of 0x000100 -> no ram_req, refresh pulses once, data_out=8'hEF.
REQ-036 Write 8'h5A to 0x000100 (line valid) -> ram_req with ram_we=1, ram_wdata=16'h5A5A, ram_wm=2'b10; a following read of 0x000100 hits with data_out=8'h5A.
REQ-037 With LINES=8, read 0x000000 then 0x000010 (same index) then 0x000000 -> three SDRAM reads.
REQ-038 Stall ram_ack during a read miss while issuing two further oe pulses -> the first is served after ack, the second is dropped, overflow=1.
REQ-039 Assert reset in RD_WAIT, then ack -> no fill, the next read of the same address misses.
